// File: rtl/d_mem_wait_resp.sv
// Wait-state data memory for the MEM-stage port: each load/store stalls the pipeline for
// LATENCY+1 cycles, then pulses done_o with the result (or addr_err_o for a bad address).
module d_mem_wait_resp #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] write_data_i,
    output logic [WIDTH-1:0] read_data_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             addr_err_o
);

    localparam int unsigned IW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             err_q;
    logic [WIDTH-1:0] read_data_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic          req;
    logic          access;
    logic          bad;
    logic [IW-1:0] idx;

    assign req    = mem_read_i | mem_write_i;
    assign access = (state_q == BUSY) && (cnt_q == 4'd0);
    assign idx    = addr_q[IW+1:2];
    // Misaligned, or any bit above the word-index field set.
    assign bad    = (addr_q[1:0] != 2'b00) || ((addr_q >> (IW + 2)) != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == IDLE) && req) begin
                wr_q    <= mem_write_i;
                addr_q  <= addr_i;
                wdata_q <= write_data_i;
            end
            if (access) begin
                err_q <= bad;
                if (!wr_q) begin
                    read_data_q <= bad ? '0 : mem[idx];
                end
            end
        end
    end

    // Array is deliberately not reset; contents survive rst_n_i.
    always_ff @(posedge clk_i) begin
        if (access && wr_q && !bad) begin
            mem[idx] <= wdata_q;
        end
    end

    // Gated by reset so a request held during reset does not stall the pipeline.
    assign stall_o     = rst_n_i & (((state_q == IDLE) & req) | (state_q == BUSY));
    assign done_o      = (state_q == DONE);
    assign addr_err_o  = (state_q == DONE) & err_q;
    assign read_data_o = read_data_q;

endmodule

// File: tb/tb_d_mem_wait_resp.sv
// Directed bench for d_mem_wait_resp (WIDTH=32, DEPTH=64, LATENCY=3).
module tb_d_mem_wait_resp;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;
    logic        stall_o;
    logic        done_o;
    logic        addr_err_o;

    int n_checks = 0;
    int n_fails  = 0;
    int mon_done = 0;
    int mon_stall = 0;

    d_mem_wait_resp #(
        .WIDTH  (32),
        .DEPTH  (64),
        .LATENCY(3)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .addr_i      (addr_i),
        .write_data_i(write_data_i),
        .read_data_o (read_data_o),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .addr_err_o  (addr_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        #2;
        if (done_o === 1'b1) mon_done++;
        if (stall_o === 1'b1) mon_stall++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request at the next negedge and holds it until done_o.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input bit hold, input bit scramble,
                             output logic [31:0] rdata, output logic err,
                             output int stalls, output int done_at);
        stalls  = 0;
        done_at = -1;
        rdata   = 'x;
        err     = 1'bx;
        @(negedge clk_i);
        mem_read_i   = rd;
        mem_write_i  = wr;
        addr_i       = addr;
        write_data_i = data;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk_i);
            if (c == 1 && scramble) begin
                addr_i       = 32'h20;
                write_data_i = 32'hFFFF_FFFF;
            end
            #1;
            if (stall_o === 1'b1) stalls++;
            if (done_o === 1'b1) begin
                done_at = c;
                err     = addr_err_o;
                rdata   = read_data_o;
                break;
            end
        end
        if (!hold) begin
            mem_read_i  = 1'b0;
            mem_write_i = 1'b0;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          st;
    int          dn;
    int          d0;
    int          s0;

    initial begin
        rst_n_i      = 1'b0;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        addr_i       = '0;
        write_data_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        check_val("rst_rdata", read_data_o, 32'h0);
        check_val("rst_stall", {31'b0, stall_o}, 32'h0);
        check_val("rst_done", {31'b0, done_o}, 32'h0);
        check_val("rst_err", {31'b0, addr_err_o}, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Store then load 0x50: timing and data
        do_access(1'b0, 1'b1, 32'h50, 32'h0000_3221, 1'b0, 1'b0, rd, er, st, dn);
        check_val("st50_stalls", st, 32'd4);
        check_val("st50_done_at", dn, 32'd4);
        check_val("st50_err", {31'b0, er}, 32'h0);
        check_val("st50_rdata_kept", rd, 32'h0);
        do_access(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("ld50_stalls", st, 32'd4);
        check_val("ld50_done_at", dn, 32'd4);
        check_val("ld50_rdata", rd, 32'h0000_3221);
        check_val("ld50_err", {31'b0, er}, 32'h0);

        // Both read and write high -> write
        do_access(1'b1, 1'b1, 32'h14, 32'hA5A5_A5A5, 1'b0, 1'b0, rd, er, st, dn);
        check_val("both_rdata_kept", rd, 32'h0000_3221);
        do_access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("ld14", rd, 32'hA5A5_A5A5);

        // Highest valid word
        do_access(1'b0, 1'b1, 32'hFC, 32'hCAFE_0FC0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("stFC_err", {31'b0, er}, 32'h0);
        do_access(1'b1, 1'b0, 32'hFC, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("ldFC", rd, 32'hCAFE_0FC0);

        // Rejected accesses
        do_access(1'b1, 1'b0, 32'h52, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("ld52_err", {31'b0, er}, 32'h1);
        check_val("ld52_rdata", rd, 32'h0);
        check_val("ld52_done_at", dn, 32'd4);
        do_access(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("ld100_err", {31'b0, er}, 32'h1);
        check_val("ld100_rdata", rd, 32'h0);
        // 0x114 would alias word 0x14 if the high bits were ignored
        do_access(1'b0, 1'b1, 32'h114, 32'h1234_5678, 1'b0, 1'b0, rd, er, st, dn);
        check_val("st114_err", {31'b0, er}, 32'h1);
        do_access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("ld14_unchanged", rd, 32'hA5A5_A5A5);
        check_val("ld14_err_clear", {31'b0, er}, 32'h0);

        // Inputs changing during BUSY are ignored
        do_access(1'b0, 1'b1, 32'h20, 32'h2020_2020, 1'b0, 1'b0, rd, er, st, dn);
        do_access(1'b0, 1'b1, 32'h18, 32'h0000_1818, 1'b0, 1'b1, rd, er, st, dn);
        do_access(1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("scr_ld18", rd, 32'h0000_1818);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("scr_ld20", rd, 32'h2020_2020);

        // Reset mid-BUSY of a store to 0x10
        do_access(1'b0, 1'b1, 32'h10, 32'h0000_1111, 1'b0, 1'b0, rd, er, st, dn);
        @(negedge clk_i);
        mem_write_i  = 1'b1;
        addr_i       = 32'h10;
        write_data_i = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk_i);
        #1;
        check_val("pre_rst_stall", {31'b0, stall_o}, 32'h1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_val("rst_mid_stall", {31'b0, stall_o}, 32'h0);
        check_val("rst_mid_done", {31'b0, done_o}, 32'h0);
        @(negedge clk_i);
        mem_write_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("rst_ld10_old", rd, 32'h0000_1111);

        // Request held through DONE, then a fresh load
        repeat (2) @(negedge clk_i);
        d0 = mon_done;
        s0 = mon_stall;
        do_access(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, rd, er, st, dn);
        do_access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, rd, er, st, dn);
        check_val("b2b_ld14", rd, 32'hA5A5_A5A5);
        repeat (6) @(negedge clk_i);
        #3;
        check_val("b2b_done_pulses", mon_done - d0, 32'd2);
        check_val("b2b_stall_cycles", mon_stall - s0, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
